dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory between the pipeline MEM stage (CPU port) and a secondary bus master such as a DMA or loader (DMA port). It sits between those requesters and the data memory and drives the memory's read enable, write enable, address and write-data inputs. Read data is registered, so each port sees a one-cycle request/response handshake. A bounded-wait rule guarantees DMA progress under continuous CPU traffic.

---
 rtl/dmem_arbiter_pkg.sv | 12 +
 rtl/dmem_port_resp.sv | 40 ++++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: port indices, default
// starvation bound and wait-counter width.
package dmem_arbiter_pkg;

    localparam int PORT_CPU         = 0;
    localparam int PORT_DMA         = 1;
    localparam int NUM_PORTS        = 2;

    localparam int MAX_WAIT_DEFAULT = 4;
    localparam int WAIT_W           = 4;

endpackage

// File: rtl/dmem_port_resp.sv
// Per-port read-response registers: captures memory read data on a granted
// read and presents it with a one-cycle rvalid pulse.
module dmem_port_resp #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gnt,
    input  logic              we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_fire;

    assign rd_fire = gnt & ~we;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_fire;
            if (rd_fire) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Reset is synchronous, so a response captured just before reset would
    // still be visible in the reset cycle; masking drops it immediately.
    assign rvalid = rvalid_q & ~reset;
    assign rdata  = reset ? '0 : rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing a single-ported data memory between the CPU
// MEM stage and a DMA master, with bounded DMA wait.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0]    wait_cnt;
    logic [NUM_PORTS-1:0] gnt;

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a signal unassigned and infers a latch.
    always_comb begin
        gnt = '0;
        if (!reset) begin
            if (dma_req && wait_cnt == MAX_WAIT_C) begin
                gnt[PORT_DMA] = 1'b1;
            end else if (cpu_req) begin
                gnt[PORT_CPU] = 1'b1;
            end else if (dma_req) begin
                gnt[PORT_DMA] = 1'b1;
            end
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[PORT_CPU]) begin
            mem_read  = ~cpu_we;
            mem_write = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (gnt[PORT_DMA]) begin
            mem_read  = ~dma_we;
            mem_write = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_gnt   = gnt[PORT_CPU];
    assign dma_gnt   = gnt[PORT_DMA];
    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Counts consecutive denied DMA cycles, saturating at the bound.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!dma_req || gnt[PORT_DMA]) begin
            wait_cnt <= '0;
        end else if (wait_cnt < MAX_WAIT_C) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    dmem_port_resp #(.DATA_W(DATA_W)) u_cpu_resp (
        .clk       (clk),
        .reset     (reset),
        .gnt       (gnt[PORT_CPU]),
        .we        (cpu_we),
        .mem_rdata (mem_rdata),
        .rvalid    (cpu_rvalid),
        .rdata     (cpu_rdata)
    );

    dmem_port_resp #(.DATA_W(DATA_W)) u_dma_resp (
        .clk       (clk),
        .reset     (reset),
        .gnt       (gnt[PORT_DMA]),
        .we        (dma_we),
        .mem_rdata (mem_rdata),
        .rvalid    (dma_rvalid),
        .rdata     (dma_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected read
// data into per-port queues; a monitor pops and compares on each rvalid.
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_stall, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt, dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] cpu_q[$];
    logic [31:0] dma_q[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory fixture: unwritten words read as 0xA000_0000 | word index.
    logic [31:0] mem [0:63];
    bit   [63:0] written;
    logic [5:0]  mem_idx;
    assign mem_idx   = mem_addr[7:2];
    assign mem_rdata = written[mem_idx] ? mem[mem_idx] : (32'hA000_0000 | 32'(mem_idx));

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_idx]     <= mem_wdata;
            written[mem_idx] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: compares every presented response against the scoreboard.
    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
            else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end
        if (dma_rvalid) begin
            if (dma_q.size() == 0) check("dma_rvalid_unexpected", 32'(dma_rvalid), 32'd0);
            else check("dma_rdata", dma_rdata, dma_q.pop_front());
        end
    end

    // Requesters must hold req and fields stable while waiting for a grant.
    logic        prev_reset, prev_cpu_wait, prev_dma_wait;
    logic [65:0] prev_cpu_f, prev_dma_f;
    always @(posedge clk) begin
        if (!reset && !prev_reset) begin
            if (prev_cpu_wait)
                assert ({cpu_req, cpu_we, cpu_addr, cpu_wdata} == prev_cpu_f)
                    else $error("protocol: cpu request changed while waiting");
            if (prev_dma_wait)
                assert ({dma_req, dma_we, dma_addr, dma_wdata} == prev_dma_f)
                    else $error("protocol: dma request changed while waiting");
        end
        prev_reset    <= reset;
        prev_cpu_wait <= cpu_req & ~cpu_gnt;
        prev_dma_wait <= dma_req & ~dma_gnt;
        prev_cpu_f    <= {cpu_req, cpu_we, cpu_addr, cpu_wdata};
        prev_dma_f    <= {dma_req, dma_we, dma_addr, dma_wdata};
    end

    // Apply one cycle of requests just after the edge, then wait for mid-cycle.
    task automatic cycle(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
        check("rst_dma_gnt",    32'(dma_gnt),    32'd0);
        check("rst_cpu_stall",  32'(cpu_stall),  32'd0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        check("rst_cpu_rdata",  cpu_rdata,       32'd0);
        check("rst_dma_rdata",  dma_rdata,       32'd0);
        check("rst_mem_rw",     32'({mem_read, mem_write}), 32'd0);
        check("rst_mem_addr",   mem_addr,        32'd0);
        check("rst_mem_wdata",  mem_wdata,       32'd0);
        check("rst_wait_cnt",   32'(dut.wait_cnt), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // CPU-only: write then read back, zero stall.
        cycle(1, 1, 32'h08, 32'h61, 0, 0, 0, 0);
        check("t1_wr_gnt",   32'(cpu_gnt),   32'd1);
        check("t1_wr_stall", 32'(cpu_stall), 32'd0);
        check("t1_mem_write", 32'(mem_write), 32'd1);
        check("t1_mem_addr", mem_addr,  32'h08);
        check("t1_mem_wdata", mem_wdata, 32'h61);
        cycle(1, 0, 32'h08, 32'h0, 0, 0, 0, 0);
        check("t1_rd_gnt",   32'(cpu_gnt),   32'd1);
        check("t1_rd_stall", 32'(cpu_stall), 32'd0);
        check("t1_mem_read", 32'(mem_read),  32'd1);
        cpu_q.push_back(32'h61);
        idle();

        // Contention: CPU wins, DMA follows next cycle.
        cycle(1, 0, 32'h0C, 32'h0, 1, 0, 32'h84, 32'h0);
        check("t2_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("t2_dma_gnt0", 32'(dma_gnt), 32'd0);
        cpu_q.push_back(32'hA000_0003);
        cycle(0, 0, 32'h0, 32'h0, 1, 0, 32'h84, 32'h0);
        check("t2_dma_gnt1", 32'(dma_gnt), 32'd1);
        check("t2_mem_addr", mem_addr, 32'h84);
        check("t2_mem_read", 32'(mem_read), 32'd1);
        dma_q.push_back(32'hA000_0021);
        idle();
        check("t2_idle_gnt", 32'({cpu_gnt, dma_gnt}), 32'd0);

        // Starvation bound: DMA forced through at cycle 4 of continuous CPU traffic.
        for (int c = 0; c < 6; c++) begin
            cycle(1, 1, 32'h30, 32'h1234, (c < 5), 0, 32'h40, 32'h0);
            check($sformatf("t3_dma_gnt_c%0d", c),   32'(dma_gnt),   32'(c == 4));
            check($sformatf("t3_cpu_gnt_c%0d", c),   32'(cpu_gnt),   32'(c != 4));
            check($sformatf("t3_cpu_stall_c%0d", c), 32'(cpu_stall), 32'(c == 4));
            check($sformatf("t3_wait_cnt_c%0d", c),  32'(dut.wait_cnt), (c <= 4) ? 32'(c) : 32'd0);
            if (c == 4) dma_q.push_back(32'hA000_0010);
        end
        idle();

        // Cross-port coherence: DMA write, then CPU read of the same word.
        cycle(0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hFFFF_FFFF);
        check("t4_dma_gnt",   32'(dma_gnt),   32'd1);
        check("t4_mem_write", 32'(mem_write), 32'd1);
        check("t4_mem_wdata", mem_wdata, 32'hFFFF_FFFF);
        cycle(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        check("t4_cpu_gnt", 32'(cpu_gnt), 32'd1);
        cpu_q.push_back(32'hFFFF_FFFF);
        idle();

        // Reset right after a granted read drops the response and blocks writes.
        cycle(1, 0, 32'h08, 32'h0, 0, 0, 32'h0, 32'h0);
        check("t5_cpu_gnt", 32'(cpu_gnt), 32'd1);
        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            cpu_req = 0; cpu_we = 0; cpu_addr = '0;
            dma_req = 1; dma_we = 1; dma_addr = 32'h14; dma_wdata = 32'hDEAD_BEEF;
            @(negedge clk);
            check($sformatf("t5_cpu_rvalid_r%0d", r), 32'(cpu_rvalid), 32'd0);
            check($sformatf("t5_cpu_rdata_r%0d", r),  cpu_rdata,       32'd0);
            check($sformatf("t5_mem_write_r%0d", r),  32'(mem_write),  32'd0);
            check($sformatf("t5_dma_gnt_r%0d", r),    32'(dma_gnt),    32'd0);
            check($sformatf("t5_mem_addr_r%0d", r),   mem_addr,        32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        @(negedge clk);
        check("t5_wait_cnt", 32'(dut.wait_cnt), 32'd0);
        cycle(1, 0, 32'h14, 32'h0, 0, 0, 32'h0, 32'h0);
        check("t5_rd_gnt", 32'(cpu_gnt), 32'd1);
        cpu_q.push_back(32'hA000_0005);
        idle();

        // Idle: memory interface quiet, no responses.
        for (int i = 0; i < 10; i++) begin
            idle();
            check($sformatf("t6_mem_rw_%0d", i),   32'({mem_read, mem_write}), 32'd0);
            check($sformatf("t6_mem_addr_%0d", i), mem_addr, 32'd0);
            check($sformatf("t6_rvalid_%0d", i),   32'({cpu_rvalid, dma_rvalid}), 32'd0);
        end

        for (int i = 0; i < 4 && (cpu_q.size() != 0 || dma_q.size() != 0); i++) idle();
        check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        check("dma_queue_drained", 32'(dma_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
